zeroriscy_data_arbiter: RTL and testbench

ZERORISCY_DATA_ARBITER -- requirements
Module: zeroriscy_data_arbiter

---
 rtl/zeroriscy_bus_pkg.sv | 14 +
 rtl/zeroriscy_data_arbiter_if.sv | 40 ++++
 rtl/zeroriscy_id_fifo.sv | 60 ++++++
 rtl/zeroriscy_data_arbiter.sv | 110 +++++++++++
 tb/tb_zeroriscy_data_arbiter.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/zeroriscy_bus_pkg.sv
// Shared definitions for the zero-riscy data-side bus: master identifiers
// and the default depth of the outstanding-transaction queue.
package zeroriscy_bus_pkg;

    typedef enum logic {
        MASTER_LSU = 1'b0,
        MASTER_DBG = 1'b1
    } master_id_e;

    localparam int ID_W              = 1;
    localparam int NUM_MASTERS       = 2;
    localparam int DEFAULT_MAX_OUTST = 2;

endpackage

// File: rtl/zeroriscy_data_arbiter_if.sv
// Bundles the two master ports and the memory-side port of the data arbiter.
// The slave modport is the arbiter's view; the master modport drives it.
interface zeroriscy_data_arbiter_if;

    logic [1:0]  m_req_i;
    logic [63:0] m_addr_i;
    logic [1:0]  m_we_i;
    logic [7:0]  m_be_i;
    logic [63:0] m_wdata_i;
    logic [1:0]  m_lock_i;
    logic [1:0]  m_gnt_o;
    logic [1:0]  m_rvalid_o;
    logic [1:0]  m_err_o;
    logic [31:0] m_rdata_o;

    logic        data_req_o;
    logic [31:0] data_addr_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_wdata_o;
    logic        data_gnt_i;
    logic        data_rvalid_i;
    logic        data_err_i;
    logic [31:0] data_rdata_i;

    modport slave (
        input  m_req_i, m_addr_i, m_we_i, m_be_i, m_wdata_i, m_lock_i,
        output m_gnt_o, m_rvalid_o, m_err_o, m_rdata_o,
        output data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
        input  data_gnt_i, data_rvalid_i, data_err_i, data_rdata_i
    );

    modport master (
        output m_req_i, m_addr_i, m_we_i, m_be_i, m_wdata_i, m_lock_i,
        input  m_gnt_o, m_rvalid_o, m_err_o, m_rdata_o,
        input  data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
        output data_gnt_i, data_rvalid_i, data_err_i, data_rdata_i
    );

endinterface

// File: rtl/zeroriscy_id_fifo.sv
// Small FIFO of owner IDs for granted-but-unanswered transactions.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module zeroriscy_id_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        empty   = (count == '0);
        full    = (count == CNT_W'(DEPTH));
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
        head    = mem[rd_ptr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/zeroriscy_data_arbiter.sv
// Two-master arbiter for the zero-riscy data port: LSU and debug/DMA share
// one memory port, with hold, lock and round-robin selection.
module zeroriscy_data_arbiter
    import zeroriscy_bus_pkg::*;
#(
    parameter int MAX_OUTST  = DEFAULT_MAX_OUTST,
    parameter int RESET_PRIO = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    zeroriscy_data_arbiter_if.slave  bus,
    output logic                     busy_o,
    output logic                     proto_err_o
);

    localparam int CNT_W = $clog2(MAX_OUTST + 1);

    master_id_e       sel;
    master_id_e       hold_id;
    master_id_e       lock_id;
    master_id_e       rr_last;
    master_id_e       head_id;
    logic             hold_valid;
    logic             lock_valid;
    logic             data_req;
    logic             grant;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [ID_W-1:0]  head_raw;
    logic [CNT_W-1:0] outst_cnt;

    // Selection: a stalled request stays put, then a lock, then round-robin.
    always_comb begin
        sel = MASTER_LSU;
        if (!rst_n) begin
            sel = MASTER_LSU;
        end else if (hold_valid) begin
            sel = hold_id;
        end else if (lock_valid) begin
            sel = lock_id;
        end else begin
            case (bus.m_req_i)
                2'b10:   sel = MASTER_DBG;
                2'b11:   sel = (rr_last == MASTER_LSU) ? MASTER_DBG : MASTER_LSU;
                default: sel = MASTER_LSU;
            endcase
        end
    end

    // A response in the same cycle frees a slot, so a full queue can still forward.
    always_comb begin
        head_id  = master_id_e'(head_raw);
        pop      = bus.data_rvalid_i & ~fifo_empty;
        data_req = rst_n & bus.m_req_i[sel] & (~fifo_full | pop);
        grant    = data_req & bus.data_gnt_i;

        bus.data_req_o   = data_req;
        bus.data_addr_o  = (sel == MASTER_DBG) ? bus.m_addr_i[63:32]  : bus.m_addr_i[31:0];
        bus.data_wdata_o = (sel == MASTER_DBG) ? bus.m_wdata_i[63:32] : bus.m_wdata_i[31:0];
        bus.data_be_o    = (sel == MASTER_DBG) ? bus.m_be_i[7:4]      : bus.m_be_i[3:0];
        bus.data_we_o    = bus.m_we_i[sel];

        bus.m_gnt_o             = '0;
        bus.m_gnt_o[sel]        = grant;
        bus.m_rvalid_o          = '0;
        bus.m_rvalid_o[head_id] = pop;
        bus.m_err_o             = '0;
        bus.m_err_o[head_id]    = pop & bus.data_err_i;
        bus.m_rdata_o           = rst_n ? bus.data_rdata_i : '0;

        busy_o = (outst_cnt != '0) | data_req;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid  <= 1'b0;
            hold_id     <= MASTER_LSU;
            lock_valid  <= 1'b0;
            lock_id     <= MASTER_LSU;
            rr_last     <= (RESET_PRIO == 0) ? MASTER_DBG : MASTER_LSU;
            proto_err_o <= 1'b0;
        end else begin
            hold_valid <= data_req & ~bus.data_gnt_i;
            hold_id    <= sel;
            if (grant) begin
                rr_last    <= sel;
                lock_valid <= bus.m_lock_i[sel];
                lock_id    <= sel;
            end
            if (bus.data_rvalid_i && fifo_empty) proto_err_o <= 1'b1;
        end
    end

    zeroriscy_id_fifo #(
        .DEPTH (MAX_OUTST),
        .WIDTH (ID_W)
    ) u_owner_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (grant),
        .push_data (ID_W'(sel)),
        .pop       (pop),
        .head      (head_raw),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (outst_cnt)
    );

endmodule

// File: tb/tb_zeroriscy_data_arbiter.sv
// Directed bench for zeroriscy_data_arbiter: a per-cycle vector table plus
// hand-written reset sequences around outstanding and unexpected responses.
module tb_zeroriscy_data_arbiter;
    import zeroriscy_bus_pkg::*;

    typedef struct {
        string       name;
        logic [1:0]  req;
        logic [1:0]  lock;
        logic        gnt;
        logic        rv;
        logic        err;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [31:0] rdata;
        logic        sel;
        logic        exp_req;
        logic [1:0]  exp_gnt;
        logic [1:0]  exp_rv;
        logic [1:0]  exp_err;
        logic        exp_busy;
        logic        exp_perr;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;
    logic perr;
    int   total = 0;
    int   bad   = 0;

    logic [1:0]  we_pat    = 2'b10;
    logic [7:0]  be_pat    = 8'hF3;
    logic [63:0] wdata_pat = 64'hBBBB_0001_AAAA_0000;

    vec_t vecs[$];

    always #5 clk = ~clk;

    zeroriscy_data_arbiter_if bus();

    zeroriscy_data_arbiter #(
        .MAX_OUTST  (2),
        .RESET_PRIO (0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .busy_o      (busy),
        .proto_err_o (perr)
    );

    function automatic vec_t mk(input string name, input logic [1:0] req, input logic [1:0] lock,
                                input logic gnt, input logic rv, input logic err,
                                input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] rdata,
                                input logic sel, input logic exp_req, input logic [1:0] exp_gnt,
                                input logic [1:0] exp_rv, input logic [1:0] exp_err,
                                input logic exp_busy, input logic exp_perr);
        vec_t v;
        v.name = name; v.req = req; v.lock = lock; v.gnt = gnt; v.rv = rv; v.err = err;
        v.a0 = a0; v.a1 = a1; v.rdata = rdata; v.sel = sel; v.exp_req = exp_req;
        v.exp_gnt = exp_gnt; v.exp_rv = exp_rv; v.exp_err = exp_err;
        v.exp_busy = exp_busy; v.exp_perr = exp_perr;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.m_req_i       = v.req;
        bus.m_lock_i      = v.lock;
        bus.m_addr_i      = {v.a1, v.a0};
        bus.data_gnt_i    = v.gnt;
        bus.data_rvalid_i = v.rv;
        bus.data_err_i    = v.err;
        bus.data_rdata_i  = v.rdata;
    endtask

    task automatic checkVector(input vec_t v);
        checkOutput({v.name, "/data_req"}, bus.data_req_o, v.exp_req);
        checkOutput({v.name, "/addr"},  bus.data_addr_o, v.sel ? v.a1 : v.a0);
        checkOutput({v.name, "/we"},    bus.data_we_o, we_pat[v.sel]);
        checkOutput({v.name, "/be"},    bus.data_be_o, v.sel ? be_pat[7:4] : be_pat[3:0]);
        checkOutput({v.name, "/wdata"}, bus.data_wdata_o, v.sel ? wdata_pat[63:32] : wdata_pat[31:0]);
        checkOutput({v.name, "/gnt"},    bus.m_gnt_o, v.exp_gnt);
        checkOutput({v.name, "/rvalid"}, bus.m_rvalid_o, v.exp_rv);
        checkOutput({v.name, "/err"},    bus.m_err_o, v.exp_err);
        checkOutput({v.name, "/rdata"},  bus.m_rdata_o, v.rdata);
        checkOutput({v.name, "/busy"},   busy, v.exp_busy);
        checkOutput({v.name, "/perr"},   perr, v.exp_perr);
    endtask

    task automatic idleInputs();
        applyStimulus(mk("idle", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0,
                         1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.m_we_i    = we_pat;
        bus.m_be_i    = be_pat;
        bus.m_wdata_i = wdata_pat;

        // Name, req, lock, gnt, rv, err, a0, a1, rdata | sel, req, gnt, rvalid, err, busy, perr
        vecs.push_back(mk("rr1",   2'b11, 2'b00, 1, 0, 0, 32'h200, 32'h300, 32'h0,        0, 1, 2'b01, 2'b00, 2'b00, 1, 0));
        vecs.push_back(mk("rr2",   2'b11, 2'b00, 1, 1, 0, 32'h200, 32'h300, 32'hA0,       1, 1, 2'b10, 2'b01, 2'b00, 1, 0));
        vecs.push_back(mk("rr3",   2'b11, 2'b00, 1, 1, 0, 32'h200, 32'h300, 32'hA1,       0, 1, 2'b01, 2'b10, 2'b00, 1, 0));
        vecs.push_back(mk("rr4",   2'b11, 2'b00, 1, 1, 0, 32'h200, 32'h300, 32'hA2,       1, 1, 2'b10, 2'b01, 2'b00, 1, 0));
        vecs.push_back(mk("rr5",   2'b00, 2'b00, 0, 1, 1, 32'h200, 32'h300, 32'hA3,       0, 0, 2'b00, 2'b10, 2'b10, 1, 0));
        vecs.push_back(mk("idle1", 2'b00, 2'b00, 0, 0, 0, 32'h200, 32'h300, 32'h0,        0, 0, 2'b00, 2'b00, 2'b00, 0, 0));
        vecs.push_back(mk("one1",  2'b01, 2'b00, 1, 0, 0, 32'h100, 32'h300, 32'h0,        0, 1, 2'b01, 2'b00, 2'b00, 1, 0));
        vecs.push_back(mk("one2",  2'b00, 2'b00, 0, 1, 0, 32'h100, 32'h300, 32'hDEADBEEF, 0, 0, 2'b00, 2'b01, 2'b00, 1, 0));
        vecs.push_back(mk("full1", 2'b01, 2'b00, 1, 0, 0, 32'h400, 32'h500, 32'h0,        0, 1, 2'b01, 2'b00, 2'b00, 1, 0));
        vecs.push_back(mk("full2", 2'b10, 2'b00, 1, 0, 0, 32'h400, 32'h500, 32'h0,        1, 1, 2'b10, 2'b00, 2'b00, 1, 0));
        vecs.push_back(mk("full3", 2'b01, 2'b00, 1, 0, 0, 32'h404, 32'h500, 32'h0,        0, 0, 2'b00, 2'b00, 2'b00, 1, 0));
        vecs.push_back(mk("full4", 2'b01, 2'b00, 1, 0, 0, 32'h404, 32'h500, 32'h0,        0, 0, 2'b00, 2'b00, 2'b00, 1, 0));
        vecs.push_back(mk("full5", 2'b01, 2'b00, 1, 1, 0, 32'h404, 32'h500, 32'hB0,       0, 1, 2'b01, 2'b01, 2'b00, 1, 0));
        vecs.push_back(mk("full6", 2'b00, 2'b00, 0, 1, 0, 32'h404, 32'h500, 32'hB1,       0, 0, 2'b00, 2'b10, 2'b00, 1, 0));
        vecs.push_back(mk("full7", 2'b00, 2'b00, 0, 1, 0, 32'h404, 32'h500, 32'hB2,       0, 0, 2'b00, 2'b01, 2'b00, 1, 0));
        vecs.push_back(mk("idle2", 2'b00, 2'b00, 0, 0, 0, 32'h404, 32'h500, 32'h0,        0, 0, 2'b00, 2'b00, 2'b00, 0, 0));
        vecs.push_back(mk("lock0", 2'b10, 2'b00, 1, 0, 0, 32'h101, 32'h600, 32'h0,        1, 1, 2'b10, 2'b00, 2'b00, 1, 0));
        vecs.push_back(mk("lock1", 2'b11, 2'b01, 1, 1, 0, 32'h101, 32'h600, 32'hC0,       0, 1, 2'b01, 2'b10, 2'b00, 1, 0));
        vecs.push_back(mk("lock2", 2'b11, 2'b00, 1, 1, 0, 32'h104, 32'h600, 32'hC1,       0, 1, 2'b01, 2'b01, 2'b00, 1, 0));
        vecs.push_back(mk("lock3", 2'b11, 2'b00, 1, 1, 0, 32'h104, 32'h600, 32'hC2,       1, 1, 2'b10, 2'b01, 2'b00, 1, 0));
        vecs.push_back(mk("lock4", 2'b00, 2'b00, 0, 1, 0, 32'h104, 32'h600, 32'hC3,       0, 0, 2'b00, 2'b10, 2'b00, 1, 0));
        vecs.push_back(mk("idle3", 2'b00, 2'b00, 0, 0, 0, 32'h104, 32'h600, 32'h0,        0, 0, 2'b00, 2'b00, 2'b00, 0, 0));
        vecs.push_back(mk("hold1", 2'b10, 2'b00, 0, 0, 0, 32'h800, 32'h700, 32'h0,        1, 1, 2'b00, 2'b00, 2'b00, 1, 0));
        vecs.push_back(mk("hold2", 2'b11, 2'b00, 0, 0, 0, 32'h800, 32'h700, 32'h0,        1, 1, 2'b00, 2'b00, 2'b00, 1, 0));
        vecs.push_back(mk("hold3", 2'b11, 2'b00, 0, 0, 0, 32'h800, 32'h700, 32'h0,        1, 1, 2'b00, 2'b00, 2'b00, 1, 0));
        vecs.push_back(mk("hold4", 2'b11, 2'b00, 1, 0, 0, 32'h800, 32'h700, 32'h0,        1, 1, 2'b10, 2'b00, 2'b00, 1, 0));
        vecs.push_back(mk("hold5", 2'b11, 2'b00, 1, 1, 0, 32'h800, 32'h700, 32'hD0,       0, 1, 2'b01, 2'b10, 2'b00, 1, 0));
        vecs.push_back(mk("hold6", 2'b00, 2'b00, 0, 1, 0, 32'h800, 32'h700, 32'hD1,       0, 0, 2'b00, 2'b01, 2'b00, 1, 0));
        vecs.push_back(mk("idle4", 2'b00, 2'b00, 0, 0, 0, 32'h800, 32'h700, 32'h0,        0, 0, 2'b00, 2'b00, 2'b00, 0, 0));
        vecs.push_back(mk("perr1", 2'b00, 2'b00, 0, 1, 0, 32'h900, 32'h700, 32'hE0,       0, 0, 2'b00, 2'b00, 2'b00, 0, 0));
        vecs.push_back(mk("perr2", 2'b00, 2'b00, 0, 0, 0, 32'h900, 32'h700, 32'h0,        0, 0, 2'b00, 2'b00, 2'b00, 0, 1));
        vecs.push_back(mk("perr3", 2'b01, 2'b00, 1, 0, 0, 32'h900, 32'h700, 32'h0,        0, 1, 2'b01, 2'b00, 2'b00, 1, 1));
        vecs.push_back(mk("perr4", 2'b00, 2'b00, 0, 1, 0, 32'h900, 32'h700, 32'hE1,       0, 0, 2'b00, 2'b01, 2'b00, 1, 1));

        // Busy inputs during reset must not leak to any control output.
        applyStimulus(mk("rst", 2'b11, 2'b11, 1, 1, 1, 32'h1000, 32'h2000, 32'h12345678,
                         0, 0, 2'b00, 2'b00, 2'b00, 0, 0));
        #2;
        checkOutput("reset/data_req", bus.data_req_o, 1'b0);
        checkOutput("reset/addr",     bus.data_addr_o, 32'h1000);
        checkOutput("reset/we",       bus.data_we_o, we_pat[0]);
        checkOutput("reset/be",       bus.data_be_o, be_pat[3:0]);
        checkOutput("reset/wdata",    bus.data_wdata_o, wdata_pat[31:0]);
        checkOutput("reset/gnt",      bus.m_gnt_o, 2'b00);
        checkOutput("reset/rvalid",   bus.m_rvalid_o, 2'b00);
        checkOutput("reset/err",      bus.m_err_o, 2'b00);
        checkOutput("reset/rdata",    bus.m_rdata_o, 32'h0);
        checkOutput("reset/busy",     busy, 1'b0);
        checkOutput("reset/perr",     perr, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idleInputs();

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #2;
            checkVector(vecs[i]);
        end

        // Reset with one transaction outstanding; its late response is unexpected.
        @(negedge clk);
        applyStimulus(mk("orst", 2'b01, 2'b00, 1, 0, 0, 32'hA00, 32'h0, 32'h0,
                         0, 0, 2'b00, 2'b00, 2'b00, 0, 0));
        #2;
        checkOutput("orst/gnt", bus.m_gnt_o, 2'b01);
        @(negedge clk);
        rst_n = 1'b0;
        idleInputs();
        #2;
        checkOutput("orst/perr_clr", perr, 1'b0);
        checkOutput("orst/busy_clr", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.data_rvalid_i = 1'b1;
        bus.data_rdata_i  = 32'hF0;
        #2;
        checkOutput("late/rvalid", bus.m_rvalid_o, 2'b00);
        checkOutput("late/busy",   busy, 1'b0);
        @(negedge clk);
        idleInputs();
        #2;
        checkOutput("late/perr_set", perr, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        checkOutput("late/perr_rst", perr, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #2;
        checkOutput("late/perr_after", perr, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
